// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: PCSrc encodings
// (also used by the branch comparator) and the fetch FSM state type.
package fetch_sequencer_pkg;

    localparam int unsigned PC_SRC_W = 2;
    localparam int unsigned INST_W   = 32;

    typedef logic [PC_SRC_W-1:0] pc_src_t;

    localparam pc_src_t PC_SEQ  = 2'b00;
    localparam pc_src_t PC_BR   = 2'b01;
    localparam pc_src_t PC_JALR = 2'b10;
    localparam pc_src_t PC_RSVD = 2'b11;

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } fetch_state_t;

    // True for the PCSrc codes that actually move the PC.
    function automatic logic is_redirect_src(input pc_src_t src);
        return (src == PC_BR) || (src == PC_JALR);
    endfunction

endpackage

// File: rtl/fetch_redirect_mux.sv
// Redirect target selection: picks branch or JALR target, clears JALR bit 0,
// and splits an effective redirect into "take" or "misaligned".
module fetch_redirect_mux
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            redirect_valid_i,
    input  pc_src_t         pc_src_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic [XLEN-1:0] jalr_target_i,
    output logic [XLEN-1:0] target_c,
    output logic            take_c,
    output logic            misalign_c
);

    logic effective;
    logic aligned;

    always_comb begin
        target_c = br_target_i;
        if (pc_src_i == PC_JALR) begin
            target_c = jalr_target_i & ~XLEN'(1);
        end
    end

    assign effective  = redirect_valid_i && is_redirect_src(pc_src_i);
    assign aligned    = (target_c[1:0] == 2'b00);
    assign take_c     = effective && aligned;
    assign misalign_c = effective && !aligned;

endmodule

// File: rtl/fetch_sequencer.sv
// RV32I fetch/PC controller: single-outstanding req/gnt/rvalid fetch, valid/ready
// hand-off to decode, and redirects that kill or flush wrong-path fetches.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              inst_ready,
    input  logic              redirect_valid,
    input  pc_src_t           pc_src,
    input  logic [XLEN-1:0]   br_target,
    input  logic [XLEN-1:0]   jalr_target,
    output logic              misalign_err
);

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic              kill_q, kill_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
    logic              misalign_q, misalign_d;
    logic              rst_sync_q;

    logic [XLEN-1:0]   redir_target_c;
    logic              redir_take_c;
    logic              redir_misalign_c;
    logic              gnt_acc_c;

    fetch_redirect_mux #(
        .XLEN (XLEN)
    ) u_redirect_mux (
        .redirect_valid_i (redirect_valid),
        .pc_src_i         (pc_src),
        .br_target_i      (br_target),
        .jalr_target_i    (jalr_target),
        .target_c         (redir_target_c),
        .take_c           (redir_take_c),
        .misalign_c       (redir_misalign_c)
    );

    // Request only once reset has been seen high for a full cycle.
    assign imem_req  = (state_q == REQ) && rst_sync_q;
    assign imem_addr = req_addr_q;
    assign gnt_acc_c = imem_gnt && imem_req;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        misalign_d   = redir_misalign_c;

        case (state_q)
            REQ: begin
                if (gnt_acc_c) begin
                    state_d = WAIT;
                end
                // The pending request still completes; its response gets dropped.
                if (redir_take_c) begin
                    pc_d   = redir_target_c;
                    kill_d = 1'b1;
                end
            end
            WAIT: begin
                if (redir_take_c) begin
                    pc_d = redir_target_c;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_pc_d    = req_addr_q;
                        inst_valid_d = 1'b1;
                        pc_d         = req_addr_q + XLEN'(4);
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir_take_c) begin
                    inst_valid_d = 1'b0;
                    pc_d         = redir_target_c;
                    state_d      = REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // Address is captured only on entry to REQ so it holds until granted.
        if ((state_d == REQ) && (state_q != REQ)) begin
            req_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            req_addr_q   <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            misalign_q   <= 1'b0;
            rst_sync_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            misalign_q   <= misalign_d;
            rst_sync_q   <= 1'b1;
        end
    end

    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus a randomized run
// checked against a delivered-PC-stream reference model.
module tb_fetch_sequencer;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt = 1'b0;
    logic            imem_rvalid = 1'b0;
    logic [31:0]     imem_rdata = '0;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [1:0]      pc_src = 2'b00;
    logic [XLEN-1:0] br_target = '0;
    logic [XLEN-1:0] jalr_target = '0;
    logic            misalign_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .pc_src         (pc_src),
        .br_target      (br_target),
        .jalr_target    (jalr_target),
        .misalign_err   (misalign_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Grant the pending request now, answer it one cycle later.
    task automatic fetch_one(input logic [31:0] data);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", inst_valid); end
        checks++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h/%h exp=0/0", inst, inst_pc); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rst_mis got=%0b exp=0", misalign_err); end
        rst_n = 1'b1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_sync_req got=%0b exp=0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rst_first_req got=%0b@%h exp=1@0", imem_req, imem_addr); end
    endtask

    task automatic test_sequential();
        fetch_one(32'h0000_0013);
        checks++; if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h0) begin failures++; $display("FAIL seq_inst0 got=%0b %h@%h exp=1 00000013@0", inst_valid, inst, inst_pc); end
        accept();
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL seq_addr4 got=%0b %0b@%h exp=0 1@4", inst_valid, imem_req, imem_addr); end
        fetch_one(mem_word(32'h4));
        checks++; if (inst !== mem_word(32'h4) || inst_pc !== 32'h4) begin failures++; $display("FAIL seq_inst1 got=%h@%h exp=%h@4", inst, inst_pc, mem_word(32'h4)); end
        accept();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL seq_addr8 got=%0b@%h exp=1@8", imem_req, imem_addr); end
    endtask

    task automatic test_hold_stall();
        fetch_one(32'hABCD_0093);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'hABCD_0093 || inst_pc !== 32'h8 || imem_req !== 1'b0) begin
                failures++; $display("FAIL hold_stable[%0d] got=%0b %h@%h req=%0b exp=1 abcd0093@8 req=0", i, inst_valid, inst, inst_pc, imem_req);
            end
            tick();
        end
        accept();
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hC) begin failures++; $display("FAIL hold_release got=%0b %0b@%h exp=0 1@c", inst_valid, imem_req, imem_addr); end
    endtask

    task automatic test_wait_redirect();
        fetch_one(mem_word(32'hC));
        accept();
        checks++; if (imem_addr !== 32'h10) begin failures++; $display("FAIL wredir_pre got=%h exp=10", imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; pc_src = 2'b01; br_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wredir_wait got=%0b exp=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL wredir_drop got=%0b %0b@%h exp=0 1@100", inst_valid, imem_req, imem_addr); end
    endtask

    task automatic test_req_redirect();
        redirect_valid = 1'b1; pc_src = 2'b10; jalr_target = 32'h201;
        tick();
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rredir_hold1 got=%0b@%h exp=1@100", imem_req, imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rredir_hold2 got=%0b@%h exp=1@100", imem_req, imem_addr); end
        fetch_one(mem_word(32'h100));
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rredir_target got=%0b %0b@%h exp=0 1@200", inst_valid, imem_req, imem_addr); end
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL rredir_mis got=%0b exp=0", misalign_err); end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; pc_src = 2'b01; br_target = 32'h102; imem_gnt = 1'b1;
        tick();
        redirect_valid = 1'b0; imem_gnt = 1'b0;
        checks++; if (misalign_err !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%0b exp=1", misalign_err); end
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h200);
        tick();
        imem_rvalid = 1'b0;
        checks++; if (misalign_err !== 1'b0) begin failures++; $display("FAIL mis_clear got=%0b exp=0", misalign_err); end
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin failures++; $display("FAIL mis_seq got=%0b@%h exp=1@200", inst_valid, inst_pc); end
        accept();
        redirect_valid = 1'b1; pc_src = 2'b11; br_target = 32'h400; jalr_target = 32'h800; imem_gnt = 1'b1;
        tick();
        redirect_valid = 1'b0; imem_gnt = 1'b0;
        checks++; if (misalign_err !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rsvd_nochg got=mis%0b req%0b exp=mis0 req0", misalign_err, imem_req); end
        imem_rvalid = 1'b1; imem_rdata = mem_word(32'h204);
        tick();
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h204) begin failures++; $display("FAIL rsvd_seq got=%0b@%h exp=1@204", inst_valid, inst_pc); end
        accept();
        checks++; if (imem_addr !== 32'h208) begin failures++; $display("FAIL rsvd_next got=%h exp=208", imem_addr); end
    endtask

    task automatic test_hold_redirect();
        fetch_one(mem_word(32'h208));
        inst_ready = 1'b1; redirect_valid = 1'b1; pc_src = 2'b01; br_target = 32'h300;
        tick();
        inst_ready = 1'b0; redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL hredir_flush got=%0b %0b@%h exp=0 1@300", inst_valid, imem_req, imem_addr); end
        fetch_one(mem_word(32'h300));
        checks++; if (inst_pc !== 32'h300 || inst !== mem_word(32'h300)) begin failures++; $display("FAIL hredir_inst got=%h@%h exp=%h@300", inst, inst_pc, mem_word(32'h300)); end
        accept();
    endtask

    task automatic test_reset_mid();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h304) begin failures++; $display("FAIL rmid_wait got=%0b@%h exp=0@304", imem_req, imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0 || inst_pc !== 32'h0) begin failures++; $display("FAIL rmid_async got=%h %0b %0b %h exp=0 0 0 0", imem_addr, imem_req, inst_valid, inst_pc); end
        @(negedge clk);
        tick();
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL rmid_release got=%0b %0b@%h exp=0 1@0", inst_valid, imem_req, imem_addr); end
        fetch_one(mem_word(32'h0));
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL rmid_first got=%0b@%h exp=1@0", inst_valid, inst_pc); end
        accept();
    endtask

    // Model: the next delivered instruction is at the last taken redirect
    // target, or 4 past the previously delivered one.
    task automatic test_random();
        logic [31:0] exp_pc, out_addr, pend_addr, bt, jt, tgt;
        logic        exp_mis, outstanding, pend_req, take, eff;
        int          lat, accepted, idle;
        logic [1:0]  src;
        exp_pc = 32'h0; exp_mis = 1'b0; outstanding = 1'b0; pend_req = 1'b0;
        out_addr = '0; pend_addr = '0; lat = 0; accepted = 0; idle = 0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            checks++; if (misalign_err !== exp_mis) begin failures++; $display("FAIL rnd_mis cyc=%0d got=%0b exp=%0b", cyc, misalign_err, exp_mis); end
            if (outstanding) begin
                checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rnd_single cyc=%0d req=%0b exp=0", cyc, imem_req); end
            end
            if (pend_req) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== pend_addr) begin failures++; $display("FAIL rnd_addr_stable cyc=%0d got=%0b@%h exp=1@%h", cyc, imem_req, imem_addr, pend_addr); end
            end
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            src = 2'($urandom_range(0, 3));
            pc_src = src;
            bt = $urandom() & 32'hFFFF_FFFC;
            jt = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: begin bt = 32'hFFFF_FFF8; jt = 32'hFFFF_FFF9; end
                1: begin bt = bt | 32'h2; jt = jt | 32'h2; end
                default: ;
            endcase
            br_target = bt; jalr_target = jt;
            tgt  = (src == 2'b10) ? {jt[31:1], 1'b0} : bt;
            eff  = redirect_valid && (src == 2'b01 || src == 2'b10);
            take = eff && (tgt[1:0] == 2'b00);
            exp_mis = eff && !take;
            if (inst_valid && inst_ready && !take) begin
                checks++;
                if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
                    failures++; $display("FAIL rnd_deliver cyc=%0d got=%h@%h exp=%h@%h", cyc, inst, inst_pc, mem_word(exp_pc), exp_pc);
                end
                exp_pc = exp_pc + 32'd4;
                accepted++;
                idle = 0;
            end
            if (take) exp_pc = tgt;
            imem_rvalid = 1'b0;
            if (outstanding) begin
                if (lat == 0) begin
                    imem_rvalid = 1'b1; imem_rdata = mem_word(out_addr); outstanding = 1'b0;
                end else begin
                    lat--;
                end
            end
            imem_gnt = 1'b0; pend_req = 1'b0;
            if (imem_req) begin
                if ($urandom_range(0, 2) != 0) begin
                    imem_gnt = 1'b1; outstanding = 1'b1; out_addr = imem_addr; lat = $urandom_range(0, 2);
                end else begin
                    pend_req = 1'b1; pend_addr = imem_addr;
                end
            end
            idle++;
            if (idle > 300) begin
                checks++; failures++;
                $display("FAIL rnd_progress cyc=%0d idle=%0d exp<=300", cyc, idle);
                break;
            end
            tick();
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        checks++; if (accepted < 200) begin failures++; $display("FAIL rnd_accepted got=%0d exp>=200", accepted); end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        test_reset();
        test_sequential();
        test_hold_stall();
        test_wait_redirect();
        test_req_redirect();
        test_misalign();
        test_hold_redirect();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
